adc_sample_ctrl: RTL
====================

// Module: adc_sample_ctrl
// PURPOSE
//  Sequencer and consumer for spi_master_adc. Periodically issues the active-low
//  start pulse, tracks the SPI frame via cs_n, and captures the 8-bit result the
//  master presents on its led bus. Keeps a boxcar average over 2**AVG_LOG2
//  samples and drives a thermometer LED bar plus a sticky timeout flag.
// PARAMETERS
//  PERIOD    1000  clk cycles from one start pulse to the next (>= 64)
//  AVG_LOG2  2     log2 of averaging window (1..4)
//  TO_CYC    255   max clk cycles spent in either wait-for-cs_n state
// PORTS
//  clk       in   1  system clock, rising edge
//  n_rst     in   1  asynchronous, active-low reset
//  en        in   1  1 = run periodic sampling; 0 = stop, clear window/err
//  cs_n      in   1  chip select from spi_master_adc, same clock domain
//  adc_data  in   8  result bus (led) from spi_master_adc
//  n_start   out  1  to master n_start; low for exactly 1 clk per request
//  avg       out  8  floor(sum of window / 2**AVG_LOG2)
//  avg_valid out  1  1-clk pulse when avg updates (window full only)
//  bar       out  8  bar[k] = (avg > 32*k)
//  err       out  1  sticky timeout flag
// BEHAVIOUR
//  Reset: n_start=1, avg=0, avg_valid=0, bar=0, err=0; cs_d=1; count=0;
//   window RAM and sum zeroed; FSM in IDLE.
//  cs_d = cs_n registered; rise = cs_n & ~cs_d; fall = ~cs_n & cs_d.
//  FSM:
//   IDLE    : en=1 -> WAIT_P with period counter cleared.
//   WAIT_P  : count to PERIOD-2, then -> START.
//   START   : n_start=0 for this cycle only -> WAIT_LO.
//   WAIT_LO : fall -> WAIT_HI; TO_CYC cycles without fall -> err=1, -> WAIT_P.
//   WAIT_HI : rise -> CAPT; TO_CYC cycles without rise -> err=1, -> WAIT_P.
//   CAPT    : sample adc_data (1 clk after rise, bus stable) -> UPD.
//   UPD     : sum <= sum + new - oldest; ring[wr] <= new; wr++ (wraps mod N);
//             fill count saturates at N; -> WAIT_P.
//  Start-to-start spacing is exactly PERIOD clks when no timeout occurs.
//  avg/bar registered in the cycle after UPD; avg_valid pulses with them only
//   if fill count == N (first N-1 samples update ring, no avg_valid/avg change).
//  sum width 8+AVG_LOG2, never overflows; avg = sum >> AVG_LOG2 (truncate).
//  bar: avg=0 -> 0x00; 1..32 -> 0x01; 193..224 -> 0x7F; 225..255 -> 0xFF.
//  en dropping mid-frame: finish current frame (up to UPD), then IDLE, clear
//   ring, sum, fill, err; avg/bar hold last value. en low in IDLE clears err.
//  rise and fall in same state are impossible (single bit); a rise seen in
//   WAIT_LO (spurious) is ignored.
//  n_start only ever low in START; never two low cycles back-to-back.
//  Async reset mid-frame: all state to reset values immediately.
// STRUCTURE
//  Shared package/header: FSM state encodings (3-bit localparams), bar
//   threshold step (32).
//  One sub-module: adc_boxcar (ring buffer + running sum + fill counter,
//   ports: clk, n_rst, clr, push, din[7:0], avg[7:0], full).
//  Top holds FSM, period/timeout counters, cs_n edge detect, bar decode.
// TESTING (spi_master_adc + spi_slave_adc, SCLK_HALF=12, PERIOD=400, AVG_LOG2=2)
//  1 reset then en=1 -> first n_start low pulse 400 clks later, width 1 clk.
//  2 slave data C5,C6,C7,C8 on successive frames -> avg_valid only after 4th;
//    avg=0xC6 (794>>2=198), bar=0x7F.
//  3 next sample 0x00 -> avg=(C6+C7+C8+00)>>2=0x95 (149), bar=0x1F.
//  4 hold slave in reset / cs_n stuck 1 (master disconnected) -> err=1 after
//    TO_CYC clks in WAIT_LO; next start still issued PERIOD later.
//  5 en=0 mid-frame -> frame completes, no further n_start; en=1 again ->
//    avg_valid absent until 4 new samples, err cleared.
//  6 assert n_rst low during WAIT_HI -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/adc_sample_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// adc_sample_ctrl_pkg
//   Shared definitions for the ADC sample controller: FSM state encodings,
//   the LED bar threshold step and the thermometer bar decode helper.
// -----------------------------------------------------------------------------
package adc_sample_ctrl_pkg;

    // FSM state encodings (3-bit).
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_P  = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_CAPT    = 3'd5,
        ST_UPD     = 3'd6
    } state_e;

    // Each LED in the bar represents one step of this size.
    localparam int BAR_STEP = 32;

    // Thermometer decode: bar[k] = (a > BAR_STEP*k).
    function automatic logic [7:0] bar_decode(input logic [7:0] a);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            b[k] = (int'(a) > BAR_STEP * k);
        end
        return b;
    endfunction

endpackage

// File: rtl/adc_boxcar.sv
// -----------------------------------------------------------------------------
// adc_boxcar
//   Boxcar averager over 2**AVG_LOG2 samples: ring buffer, running sum and a
//   saturating fill counter. The running sum adds the new sample and removes
//   the one it overwrites; cleared ring entries read as zero, so the sum is
//   correct while the window is still filling.
// Ports
//   clk   in   system clock, rising edge
//   n_rst in   asynchronous active-low reset
//   clr   in   synchronous clear of ring, sum and fill counter
//   push  in   write din into the window this cycle
//   din   in   8-bit sample
//   avg   out  floor(sum / 2**AVG_LOG2)
//   full  out  window holds 2**AVG_LOG2 samples
// -----------------------------------------------------------------------------
import adc_sample_ctrl_pkg::*;

module adc_boxcar #(
    parameter int AVG_LOG2 = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       push,
    input  logic [7:0] din,
    output logic [7:0] avg,
    output logic       full
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = 8 + AVG_LOG2;

    logic [7:0]          ring_q [N];
    logic [AVG_LOG2-1:0] wr_q;
    logic [AVG_LOG2:0]   fill_q;
    logic [SW-1:0]       sum_q;
    logic [SW-1:0]       sum_d;

    // ring_q[wr_q] is the oldest sample, the one about to be overwritten.
    assign sum_d = sum_q + SW'(din) - SW'(ring_q[wr_q]);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < N; i++) ring_q[i] <= '0;
            wr_q   <= '0;
            fill_q <= '0;
            sum_q  <= '0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) ring_q[i] <= '0;
            wr_q   <= '0;
            fill_q <= '0;
            sum_q  <= '0;
        end else if (push) begin
            ring_q[wr_q] <= din;
            wr_q         <= wr_q + 1'b1;   // power-of-two depth wraps naturally
            sum_q        <= sum_d;
            if (fill_q != (AVG_LOG2+1)'(N)) fill_q <= fill_q + 1'b1;
        end
    end

    assign avg  = sum_q[SW-1:AVG_LOG2];
    assign full = (fill_q == (AVG_LOG2+1)'(N));

endmodule

// File: rtl/adc_sample_ctrl.sv
// -----------------------------------------------------------------------------
// adc_sample_ctrl
//   Sequencer/consumer for spi_master_adc. Issues a 1-clk active-low start
//   request every PERIOD clocks, follows the SPI frame through cs_n edges,
//   captures the result one clock after cs_n rises, and feeds it to a boxcar
//   averager. Drives the average, a thermometer LED bar and a sticky timeout
//   flag.
// Ports
//   clk       in   system clock, rising edge
//   n_rst     in   asynchronous active-low reset
//   en        in   1 = periodic sampling; 0 = stop after current frame, clear
//   cs_n      in   chip select from the master (same clock domain)
//   adc_data  in   8-bit result bus from the master
//   n_start   out  start request, low for exactly one clock
//   avg       out  window average (updates only once the window is full)
//   avg_valid out  1-clk pulse when avg/bar update
//   bar       out  thermometer bar, bar[k] = avg > 32*k
//   err       out  sticky cs_n timeout flag, cleared in IDLE
// Handshake: there is no backpressure; avg_valid is a single-cycle qualifier
//   for avg/bar, which then hold their value until the next update.
// -----------------------------------------------------------------------------
import adc_sample_ctrl_pkg::*;

module adc_sample_ctrl #(
    parameter int PERIOD   = 1000,
    parameter int AVG_LOG2 = 2,
    parameter int TO_CYC   = 255
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    input  logic       cs_n,
    input  logic [7:0] adc_data,
    output logic       n_start,
    output logic [7:0] avg,
    output logic       avg_valid,
    output logic [7:0] bar,
    output logic       err
);

    // Period counter must cover a full frame including two timeouts; it
    // saturates so a long frame can never wrap it back below the threshold.
    localparam int PW   = $clog2(PERIOD + 2 * TO_CYC + 16);
    localparam int TO_W = $clog2(TO_CYC + 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;
    logic [7:0]      sample_q, sample_d;
    logic            cs_d_q;
    logic            rise, fall;
    logic            push, clr;
    logic            upd_q;
    logic [7:0]      avg_q;
    logic [7:0]      bar_q;
    logic            avg_valid_q;
    logic [7:0]      bc_avg;
    logic            bc_full;

    assign rise    = cs_n & ~cs_d_q;
    assign fall    = ~cs_n & cs_d_q;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_inc;
        to_d     = to_q;
        err_d    = err_q;
        sample_d = sample_q;
        push     = 1'b0;
        clr      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Window and error are held cleared for as long as we idle.
                clr   = 1'b1;
                err_d = 1'b0;
                cnt_d = '0;
                if (en) state_d = ST_WAIT_P;
            end
            ST_WAIT_P: begin
                // Counter runs from the last START, so start-to-start spacing
                // is PERIOD regardless of how long the frame took.
                if (!en)                          state_d = ST_IDLE;
                else if (cnt_q >= PW'(PERIOD - 2)) state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                to_d    = '0;
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (fall) begin
                    to_d    = '0;
                    state_d = ST_WAIT_HI;
                end else if (to_q == TO_W'(TO_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_P;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (rise) begin
                    state_d = ST_CAPT;
                end else if (to_q == TO_W'(TO_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_P;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_CAPT: begin
                // One clock after the rising cs_n edge the bus is stable.
                sample_d = adc_data;
                state_d  = ST_UPD;
            end
            ST_UPD: begin
                push    = 1'b1;
                state_d = ST_WAIT_P;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            to_q     <= '0;
            err_q    <= 1'b0;
            sample_q <= '0;
            cs_d_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            err_q    <= err_d;
            sample_q <= sample_d;
            cs_d_q   <= cs_n;
        end
    end

    adc_boxcar #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_boxcar (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (clr),
        .push  (push),
        .din   (sample_q),
        .avg   (bc_avg),
        .full  (bc_full)
    );

    // The boxcar shows the post-update sum the cycle after UPD; latch it then.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            upd_q       <= 1'b0;
            avg_q       <= '0;
            bar_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            upd_q       <= push;
            avg_valid_q <= upd_q & bc_full;
            if (upd_q && bc_full) begin
                avg_q <= bc_avg;
                bar_q <= bar_decode(bc_avg);
            end
        end
    end

    assign n_start   = (state_q != ST_START);
    assign avg       = avg_q;
    assign bar       = bar_q;
    assign avg_valid = avg_valid_q;
    assign err       = err_q;

endmodule
